// File: rtl/fft_scale_restore_unit_if.sv
// ---------------------------------------------------------------------------
// fft_scale_restore_unit_if
// Sample stream bundle used on both sides of fft_scale_restore_unit.
//   data_real / data_imag : signed sample components
//   valid / ready         : handshake, transfer when both are high
//   last                  : last sample of a frame (driven by the master)
// Modports:
//   master : drives data, valid, last; receives ready
//   slave  : receives data and valid; drives ready (frame marker not consumed)
// ---------------------------------------------------------------------------
interface fft_scale_restore_unit_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] data_real;
    logic [DATA_WIDTH-1:0] data_imag;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (
        output data_real, data_imag, valid, last,
        input  ready
    );

    modport slave (
        input  data_real, data_imag, valid,
        output ready
    );
endinterface

// File: rtl/fft_scale_restore_unit.sv
// ---------------------------------------------------------------------------
// fft_scale_restore_unit
// Restores the true magnitude of frame-based FFT results by left-shifting
// every sample of a frame by the accumulated rescale count, with optional
// saturation and a per-frame count of overflowing samples.
// Ports:
//   clk_i, reset_n_i   : clock (rising edge) and asynchronous active-low reset
//   enable_i           : low stalls intake (output still drains)
//   saturation_en_i    : 1 = clamp on overflow, 0 = keep low DATA_WIDTH bits
//   frame_len_i        : samples per frame (0 treated as 1), latched per frame
//   scale_factor_i     : shift amount, latched on the first beat of a frame
//   in_if  (slave)     : input sample stream
//   out_if (master)    : restored sample stream with last-of-frame marker
//   frame_done_o       : pulse when the last beat of a frame transfers out
//   busy_o             : frame in progress or output register occupied
//   applied_shift_o    : shift used for the current/last frame
//   sat_count_o        : overflowing samples in the current/last frame
// ---------------------------------------------------------------------------
module fft_scale_restore_unit #(
    parameter int DATA_WIDTH         = 16,
    parameter int SCALE_FACTOR_WIDTH = 8,
    parameter int FRAME_LEN_WIDTH    = 12
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    input  logic                          saturation_en_i,
    input  logic [FRAME_LEN_WIDTH-1:0]    frame_len_i,
    input  logic [SCALE_FACTOR_WIDTH-1:0] scale_factor_i,
    fft_scale_restore_unit_if.slave       in_if,
    fft_scale_restore_unit_if.master      out_if,
    output logic                          frame_done_o,
    output logic                          busy_o,
    output logic [4:0]                    applied_shift_o,
    output logic [7:0]                    sat_count_o
);
    localparam int EXT_W     = DATA_WIDTH + 15;
    localparam int MAX_SHIFT = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                      state_q, state_d;
    logic [FRAME_LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [FRAME_LEN_WIDTH-1:0]  len_q, len_d;
    logic [4:0]                  shift_q, shift_d;
    logic [7:0]                  sat_q, sat_d;
    logic                        last_d;
    logic [DATA_WIDTH-1:0]       real_q, imag_q;
    logic                        valid_q, last_q;

    logic                        accept;
    logic [31:0]                 sf_wide;
    logic [4:0]                  shift_new, shift_use;
    logic [FRAME_LEN_WIDTH-1:0]  len_new;
    logic [1:0][DATA_WIDTH-1:0]  comp_in, comp_out;
    logic [1:0]                  comp_ovf;
    logic                        sample_ovf;

    // Reset gating keeps the accept signal low while reset is held.
    assign in_if.ready = reset_n_i && enable_i && (!valid_q || out_if.ready);
    assign accept      = in_if.valid && in_if.ready;

    assign sf_wide   = 32'(scale_factor_i);
    assign shift_new = (sf_wide > 32'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : 5'(sf_wide);
    // The first beat of a frame already uses the shift being latched.
    assign shift_use = (state_q == IDLE) ? shift_new : shift_q;
    assign len_new   = (frame_len_i == '0) ? FRAME_LEN_WIDTH'(1) : frame_len_i;

    assign comp_in[0] = in_if.data_real;
    assign comp_in[1] = in_if.data_imag;

    // Per component: 15 guard bits hold any shift up to DATA_WIDTH-1 without
    // loss, so overflow is simply "upper bits are not all copies of the sign".
    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
        logic [EXT_W-1:0] ext;
        logic [EXT_W-1:0] shl;
        assign ext           = {{15{comp_in[gi][DATA_WIDTH-1]}}, comp_in[gi]};
        assign shl           = ext << shift_use;
        assign comp_ovf[gi]  = !((&shl[EXT_W-1:DATA_WIDTH-1]) ||
                                 !(|shl[EXT_W-1:DATA_WIDTH-1]));
        assign comp_out[gi]  = (comp_ovf[gi] && saturation_en_i)
                             ? (shl[EXT_W-1] ? NEG_MIN : POS_MAX)
                             : shl[DATA_WIDTH-1:0];
    end

    assign sample_ovf = |comp_ovf;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        shift_d = shift_q;
        sat_d   = sat_q;
        last_d  = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    shift_d = shift_new;
                    len_d   = len_new;
                    sat_d   = {7'd0, sample_ovf};
                    if (len_new == FRAME_LEN_WIDTH'(1)) begin
                        // Single-beat frame: complete immediately.
                        last_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = FRAME_LEN_WIDTH'(1);
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sample_ovf && (sat_q != 8'hFF)) begin
                        sat_d = sat_q + 8'd1;
                    end
                    if (cnt_q == len_q - FRAME_LEN_WIDTH'(1)) begin
                        last_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + FRAME_LEN_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            sat_q   <= '0;
            real_q  <= '0;
            imag_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            sat_q   <= sat_d;
            if (accept) begin
                valid_q <= 1'b1;
                real_q  <= comp_out[0];
                imag_q  <= comp_out[1];
                last_q  <= last_d;
            end else if (out_if.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_if.data_real = real_q;
    assign out_if.data_imag = imag_q;
    assign out_if.valid     = valid_q;
    assign out_if.last      = last_q;
    assign frame_done_o     = valid_q && out_if.ready && last_q;
    assign busy_o           = (state_q == ACTIVE) || valid_q;
    assign applied_shift_o  = shift_q;
    assign sat_count_o      = sat_q;
endmodule

// File: tb/tb_fft_scale_restore_unit.sv
module tb_fft_scale_restore_unit;
    localparam int DW  = 16;
    localparam int SFW = 8;
    localparam int FLW = 12;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           enable = 1'b0;
    logic           sat_en = 1'b0;
    logic [FLW-1:0] frame_len = '0;
    logic [SFW-1:0] scale = '0;
    logic           frame_done;
    logic           busy;
    logic [4:0]     applied_shift;
    logic [7:0]     sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    fft_scale_restore_unit_if #(.DATA_WIDTH(DW)) in_bus ();
    fft_scale_restore_unit_if #(.DATA_WIDTH(DW)) out_bus ();

    assign in_bus.last = 1'b0;

    fft_scale_restore_unit #(
        .DATA_WIDTH(DW), .SCALE_FACTOR_WIDTH(SFW), .FRAME_LEN_WIDTH(FLW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
        .saturation_en_i(sat_en), .frame_len_i(frame_len),
        .scale_factor_i(scale), .in_if(in_bus), .out_if(out_bus),
        .frame_done_o(frame_done), .busy_o(busy),
        .applied_shift_o(applied_shift), .sat_count_o(sat_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic v);
        in_bus.data_real = re;
        in_bus.data_imag = im;
        in_bus.valid     = v;
    endtask

    task automatic drain();
        drive(16'h0000, 16'h0000, 1'b0);
        tick();
        chk("drain_valid", 32'(out_bus.valid), 32'd0);
        chk("drain_done", 32'(frame_done), 32'd0);
    endtask

    logic [DW-1:0] t2_in  [3] = '{16'h1000, 16'hF000, 16'hE000};
    logic [DW-1:0] t2_exp [3] = '{16'h7FFF, 16'h8000, 16'h8000};
    logic [7:0]    t2_sat [3] = '{8'd1, 8'd1, 8'd2};
    logic [DW-1:0] t3_in  [2] = '{16'h1000, 16'h3001};
    logic [DW-1:0] t3_exp [2] = '{16'h8000, 16'h8008};

    initial begin
        drive(16'h0000, 16'h0000, 1'b0);
        out_bus.ready = 1'b1;
        enable = 1'b1;
        #2;
        // Reset state
        chk("rst_valid", 32'(out_bus.valid), 32'd0);
        chk("rst_real", 32'(out_bus.data_real), 32'd0);
        chk("rst_ready", 32'(in_bus.ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shift", 32'(applied_shift), 32'd0);
        chk("rst_sat", 32'(sat_count), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        $display("[TB] reset checked");

        // Basic 4-beat frame, shift 3
        sat_en = 1'b1; scale = 8'd3; frame_len = 12'd4;
        for (int i = 0; i < 4; i++) begin
            drive(16'h0100 + 16'(i), 16'hFF00, 1'b1);
            chk("t1_ready", 32'(in_bus.ready), 32'd1);
            tick();
            chk("t1_valid", 32'(out_bus.valid), 32'd1);
            chk("t1_real", 32'(out_bus.data_real), 32'(16'h0800 + 16'(8 * i)));
            chk("t1_imag", 32'(out_bus.data_imag), 32'h0000F800);
            chk("t1_last", 32'(out_bus.last), 32'(i == 3));
            chk("t1_done", 32'(frame_done), 32'(i == 3));
            $display("[TB] t1 beat %0d real=%h imag=%h", i, out_bus.data_real, out_bus.data_imag);
        end
        chk("t1_sat", 32'(sat_count), 32'd0);
        chk("t1_shift", 32'(applied_shift), 32'd3);
        drain();
        chk("t1_busy", 32'(busy), 32'd0);

        // Saturation on, 3-beat frame
        frame_len = 12'd3;
        for (int i = 0; i < 3; i++) begin
            drive(t2_in[i], 16'h0000, 1'b1);
            tick();
            chk("t2_real", 32'(out_bus.data_real), 32'(t2_exp[i]));
            chk("t2_sat", 32'(sat_count), 32'(t2_sat[i]));
            chk("t2_last", 32'(out_bus.last), 32'(i == 2));
            $display("[TB] t2 beat %0d real=%h sat=%0d", i, out_bus.data_real, sat_count);
        end
        drain();

        // Saturation off: wrap, still counted
        sat_en = 1'b0; frame_len = 12'd2;
        for (int i = 0; i < 2; i++) begin
            drive(t3_in[i], 16'h0000, 1'b1);
            tick();
            chk("t3_real", 32'(out_bus.data_real), 32'(t3_exp[i]));
            chk("t3_sat", 32'(sat_count), 32'(i + 1));
            $display("[TB] t3 beat %0d real=%h sat=%0d", i, out_bus.data_real, sat_count);
        end
        drain();

        // Shift clamp to 15, frame_len 0 treated as single beat
        sat_en = 1'b1; scale = 8'd20; frame_len = 12'd0;
        drive(16'h0001, 16'hFFFF, 1'b1);
        tick();
        chk("t4_shift", 32'(applied_shift), 32'd15);
        chk("t4_real", 32'(out_bus.data_real), 32'h00007FFF);
        chk("t4_imag", 32'(out_bus.data_imag), 32'h00008000);
        chk("t4_last", 32'(out_bus.last), 32'd1);
        chk("t4_done", 32'(frame_done), 32'd1);
        chk("t4_sat", 32'(sat_count), 32'd1);
        $display("[TB] t4 real=%h imag=%h shift=%0d", out_bus.data_real, out_bus.data_imag, applied_shift);
        drain();
        chk("t4_busy", 32'(busy), 32'd0);

        // Mid-frame scale/len changes ignored; enable-low stall
        scale = 8'd2; frame_len = 12'd4;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                enable = 1'b0;
                drive(16'h0012, 16'hFFFF, 1'b1);
                #1;
                chk("t5_stall_ready", 32'(in_bus.ready), 32'd0);
                tick();
                chk("t5_stall_valid", 32'(out_bus.valid), 32'd0);
                chk("t5_stall_busy", 32'(busy), 32'd1);
                enable = 1'b1;
            end
            drive(16'h0010 + 16'(i), 16'hFFFF, 1'b1);
            tick();
            if (i == 0) begin
                scale = 8'd5;
                frame_len = 12'd2;
            end
            chk("t5_real", 32'(out_bus.data_real), 32'(16'h0040 + 16'(4 * i)));
            chk("t5_imag", 32'(out_bus.data_imag), 32'h0000FFFC);
            chk("t5_last", 32'(out_bus.last), 32'(i == 3));
            $display("[TB] t5 beat %0d real=%h", i, out_bus.data_real);
        end
        chk("t5_shift", 32'(applied_shift), 32'd2);
        drain();

        // Backpressure
        scale = 8'd1; frame_len = 12'd4;
        drive(16'h0005, 16'hFFFB, 1'b1);
        tick();
        chk("t6_real0", 32'(out_bus.data_real), 32'h0000000A);
        out_bus.ready = 1'b0;
        drive(16'h0006, 16'h0000, 1'b1);
        #1;
        chk("t6_ready_low", 32'(in_bus.ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_hold_real", 32'(out_bus.data_real), 32'h0000000A);
            chk("t6_hold_imag", 32'(out_bus.data_imag), 32'h0000FFF6);
            chk("t6_hold_valid", 32'(out_bus.valid), 32'd1);
            chk("t6_hold_ready", 32'(in_bus.ready), 32'd0);
            $display("[TB] t6 stall %0d real=%h", k, out_bus.data_real);
        end
        out_bus.ready = 1'b1;
        #1;
        chk("t6_ready_rel", 32'(in_bus.ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            if (i > 1) drive(16'h0005 + 16'(i), 16'h0000, 1'b1);
            tick();
            chk("t6_real", 32'(out_bus.data_real), 32'(16'h000A + 16'(2 * i)));
            chk("t6_last", 32'(out_bus.last), 32'(i == 3));
            $display("[TB] t6 beat %0d real=%h", i, out_bus.data_real);
        end
        drain();

        // Reset mid-frame
        scale = 8'd1; frame_len = 12'd4;
        for (int i = 0; i < 2; i++) begin
            drive(16'h0001 + 16'(i), 16'h0000, 1'b1);
            tick();
        end
        drive(16'h0000, 16'h0000, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t7_valid", 32'(out_bus.valid), 32'd0);
        chk("t7_real", 32'(out_bus.data_real), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_shift", 32'(applied_shift), 32'd0);
        reset_n = 1'b1;
        scale = 8'd4;
        drive(16'h0003, 16'h0000, 1'b1);
        tick();
        chk("t7_new_real", 32'(out_bus.data_real), 32'h00000030);
        chk("t7_new_shift", 32'(applied_shift), 32'd4);
        chk("t7_new_last", 32'(out_bus.last), 32'd0);
        chk("t7_new_busy", 32'(busy), 32'd1);
        $display("[TB] t7 real=%h shift=%0d", out_bus.data_real, applied_shift);
        drive(16'h0000, 16'h0000, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_scale_restore_unit.md
Name: fft_scale_restore_unit

Overview:
Output-side counterpart of the FFT rescale unit. It takes frame-based FFT result samples and the accumulated scale factor (count of divide-by-2 rescales). It left-shifts every sample of the frame by that factor to restore true magnitude, with optional saturation and per-frame saturation statistics. It sits between the FFT result buffer read port and the output interface, with valid/ready handshakes on both sides.

Parameters:
DATA_WIDTH, 16, signed two's-complement width of each real/imag component
SCALE_FACTOR_WIDTH, 8, width of the scale factor input
FRAME_LEN_WIDTH, 12, width of the frame length input

Ports:
clk_i  input  1  clock, all logic on rising edge
reset_n_i  input  1  asynchronous active-low reset
enable_i  input  1  block enable; low forces data_ready_o low
saturation_en_i  input  1  1 = saturate on overflow, 0 = wrap (keep low DATA_WIDTH bits)
frame_len_i  input  FRAME_LEN_WIDTH  samples per frame; 0 treated as 1
scale_factor_i  input  SCALE_FACTOR_WIDTH  shift amount, sampled on first beat of frame
data_real_i  input  DATA_WIDTH  input sample real part
data_imag_i  input  DATA_WIDTH  input sample imag part
data_valid_i  input  1  input sample valid
data_ready_o  output  1  input accept
data_real_o  output  DATA_WIDTH  restored real part
data_imag_o  output  DATA_WIDTH  restored imag part
data_valid_o  output  1  output sample valid
data_last_o  output  1  output sample is last of frame
data_ready_i  input  1  downstream accept
frame_done_o  output  1  one-cycle pulse when last output beat transfers
busy_o  output  1  high in ACTIVE state or while data_valid_o high
applied_shift_o  output  5  shift in use for current/last frame
sat_count_o  output  8  saturated samples in current/last frame

Behaviour:
- Reset: all outputs 0; state IDLE; sample counter 0; output register empty.
- Input handshake: accept = data_valid_i && data_ready_o. data_ready_o = enable_i && (!data_valid_o || data_ready_i). This is a single-stage pipeline and supports full throughput of one sample per cycle.
- Latency: 1 cycle from accept to data_valid_o.
- Output: data_*_o, data_last_o, data_valid_o hold stable while data_valid_o && !data_ready_i. data_valid_o clears on transfer unless a new accept occurs in the same cycle.
- FSM IDLE: the first accept latches shift = min(scale_factor_i, DATA_WIDTH-1) into applied_shift_o. The same sample uses this new shift. sat_count clears to 0, or to 1 if this sample saturates. Counter is set to 1. Go to ACTIVE. If frame_len <= 1, stay IDLE and mark the beat last.
- FSM ACTIVE: each accept increments the counter. The accept where counter == frame_len-1 marks last, clears the counter, and returns to IDLE. scale_factor_i and frame_len_i changes mid-frame are ignored; frame_len is latched with shift.
- Arithmetic: each component is sign-extended to DATA_WIDTH+15 bits, then shifted left.
  - saturation_en_i=1: result > 2^(DW-1)-1 gives 0x7FFF; result < -2^(DW-1) gives 0x8000.
  - saturation_en_i=0: low DW bits.
  - Shift 0 passes data through unchanged.
- sat_count: +1 per sample where real or imag overflowed, counted in both sat modes. It saturates at 255 and holds after the frame until the next frame's first accept.
- frame_done_o: pulses on the cycle data_valid_o && data_ready_i && data_last_o.
- enable_i low mid-frame: intake stalls; FSM, counter and pending output are retained; the output still drains.
- Reset mid-frame: immediate return to reset state; the pending output is discarded.

Test Plan:
- Shift 3, frame_len 4, sat on, real 0x0100, imag 0xFF00 -> outputs 0x0800, 0xF800 after 1 cycle. data_last_o on 4th beat; frame_done_o pulses once; sat_count_o 0.
- Shift 3, sat on: 0x1000 -> 0x7FFF; 0xF000 -> 0x8000 (exact, no sat); 0xE000 -> 0x8000 (sat). Frame of these 3 samples with frame_len 3 -> sat_count_o 2.
- Sat off, shift 3: 0x1000 -> 0x8000 (wrap), 0x3001 -> 0x8008; sat_count_o still counts 2.
- scale_factor_i 20 -> applied_shift_o 15. Also, scale_factor_i changed from 2 to 5 after beat 1 of a 4-beat frame -> all 4 beats shifted by 2.
- Backpressure: data_ready_i low 3 cycles with a valid output -> data_*_o stable, data_ready_o low. Releasing it gives 1 sample/cycle streaming with no loss or duplication.
- Reset asserted mid-frame (beat 2 of 4) -> all outputs 0 asynchronously. The next accept starts a new frame, latching the new scale factor.
